// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: qualifies a synchronized lock indicator, then releases a
// downstream reset and, after a hold interval, asserts ready. Lock losses are counted.
`timescale 1ns/1ps

module pll_reset_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic       clock_in,
  input  logic       resetb,
  input  logic       locked,
  output logic       sys_resetb,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] lock_loss_count
);

  localparam logic [1:0] StWait = 2'd0;
  localparam logic [1:0] StQual = 2'd1;
  localparam logic [1:0] StHold = 2'd2;
  localparam logic [1:0] StRun  = 2'd3;

  localparam logic [15:0] LockLast = 16'(LOCK_CYCLES - 1);
  localparam logic [15:0] HoldLast = 16'(HOLD_CYCLES - 1);

  // Only the first stage samples the asynchronous lock input.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sys_resetb_q, sys_resetb_d;
  logic        ready_q, ready_d;
  logic [7:0]  loss_cnt_q, loss_cnt_d;
  logic        loss_inc;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  // Counter is cleared on every state entry, so it never exceeds the
  // terminal value of the state it is counting in.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_inc = 1'b0;
    case (state_q)
      StWait: begin
        cnt_d = '0;
        if (locked_s) begin
          state_d = StQual;
        end
      end
      StQual: begin
        if (!locked_s) begin
          state_d = StWait;
          cnt_d   = '0;
        end else if (cnt_q == LockLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StHold: begin
        if (!locked_s) begin
          state_d  = StWait;
          cnt_d    = '0;
          loss_inc = 1'b1;
        end else if (cnt_q == HoldLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d  = StWait;
          loss_inc = 1'b1;
        end
      end
      default: begin
        state_d = StWait;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state they belong to.
  always_comb begin
    sys_resetb_d = (state_d == StHold) || (state_d == StRun);
    ready_d      = (state_d == StRun);
    loss_cnt_d   = loss_cnt_q;
    if (loss_inc && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      state_q      <= StWait;
      cnt_q        <= '0;
      sys_resetb_q <= 1'b0;
      ready_q      <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sys_resetb_q <= sys_resetb_d;
      ready_q      <= ready_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  assign sys_resetb      = sys_resetb_q;
  assign ready           = ready_q;
  assign state           = state_q;
  assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with LOCK_CYCLES=8, HOLD_CYCLES=4, SYNC_STAGES=2.
`timescale 1ns/1ps

module tb_pll_reset_seq;

  logic       clock_in = 1'b0;
  logic       resetb   = 1'b0;
  logic       locked   = 1'b0;
  logic       sys_resetb;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lock_loss_count;

  int checks   = 0;
  int failures = 0;

  pll_reset_seq #(
    .SYNC_STAGES(2),
    .LOCK_CYCLES(8),
    .HOLD_CYCLES(4)
  ) dut (
    .clock_in       (clock_in),
    .resetb         (resetb),
    .locked         (locked),
    .sys_resetb     (sys_resetb),
    .ready          (ready),
    .state          (state),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int i;
    i = 0;
    while (state !== s && i < budget) begin
      tick(1);
      i++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  initial begin
    // Reset state, before and after clock edges
    resetb = 1'b0;
    locked = 1'b1;
    #2;
    check("rst_async_sys_resetb", 32'(sys_resetb), 0);
    check("rst_async_state", 32'(state), 0);
    tick(2);
    check("rst_sys_resetb", 32'(sys_resetb), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_state", 32'(state), 0);
    check("rst_count", 32'(lock_loss_count), 0);

    // Locked held high from reset release
    @(negedge clock_in);
    resetb = 1'b1;
    tick(2);
    check("e2_state_wait", 32'(state), 0);
    tick(1);
    check("e3_state_qual", 32'(state), 1);
    tick(7);
    check("e10_sys_resetb_low", 32'(sys_resetb), 0);
    check("e10_state_qual", 32'(state), 1);
    tick(1);
    check("e11_sys_resetb_high", 32'(sys_resetb), 1);
    check("e11_state_hold", 32'(state), 2);
    check("e11_ready_low", 32'(ready), 0);
    tick(3);
    check("e14_ready_low", 32'(ready), 0);
    tick(1);
    check("e15_ready_high", 32'(ready), 1);
    check("e15_state_run", 32'(state), 3);
    check("e15_count", 32'(lock_loss_count), 0);

    // One-cycle lock drop in RUN
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(1);
    check("drop_d2_sys_resetb", 32'(sys_resetb), 1);
    tick(1);
    check("drop_d3_sys_resetb", 32'(sys_resetb), 0);
    check("drop_d3_ready", 32'(ready), 0);
    check("drop_d3_state", 32'(state), 0);
    check("drop_d3_count", 32'(lock_loss_count), 1);
    tick(1);
    check("requal_state", 32'(state), 1);
    tick(7);
    check("requal_sys_resetb_low", 32'(sys_resetb), 0);
    tick(1);
    check("requal_sys_resetb_high", 32'(sys_resetb), 1);
    tick(4);
    check("requal_ready", 32'(ready), 1);

    // Lock loss in RUN, requalify, then lose lock in HOLD at counter 2
    locked = 1'b0;
    tick(3);
    check("loss2_state", 32'(state), 0);
    check("loss2_count", 32'(lock_loss_count), 2);
    locked = 1'b1;
    tick(3);
    check("hold_drop_qual", 32'(state), 1);
    tick(8);
    check("hold_drop_in_hold", 32'(state), 2);
    locked = 1'b0;
    tick(1);
    check("hold_drop_e12_state", 32'(state), 2);
    check("hold_drop_e12_ready", 32'(ready), 0);
    tick(1);
    check("hold_drop_e13_state", 32'(state), 2);
    check("hold_drop_e13_ready", 32'(ready), 0);
    tick(1);
    check("hold_drop_e14_state", 32'(state), 0);
    check("hold_drop_e14_ready", 32'(ready), 0);
    check("hold_drop_e14_sys_resetb", 32'(sys_resetb), 0);
    check("hold_drop_e14_count", 32'(lock_loss_count), 3);

    // Short lock pulse never releases reset, and loss in QUAL is not counted
    locked = 1'b1;
    tick(3);
    check("pulse_qual", 32'(state), 1);
    tick(2);
    locked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("pulse_sys_resetb", 32'(sys_resetb), 0);
    end
    check("pulse_state", 32'(state), 0);
    check("pulse_count", 32'(lock_loss_count), 3);
    locked = 1'b1;
    tick(3);
    check("steady_qual", 32'(state), 1);
    tick(7);
    check("steady_sys_resetb_low", 32'(sys_resetb), 0);
    tick(1);
    check("steady_sys_resetb_high", 32'(sys_resetb), 1);
    check("steady_state_hold", 32'(state), 2);

    // Asynchronous reset mid-HOLD
    tick(1);
    check("midhold_state", 32'(state), 2);
    #1;
    resetb = 1'b0;
    #1;
    check("async_sys_resetb", 32'(sys_resetb), 0);
    check("async_ready", 32'(ready), 0);
    check("async_state", 32'(state), 0);
    check("async_count", 32'(lock_loss_count), 0);
    @(negedge clock_in);
    resetb = 1'b1;

    // 300 lock losses from RUN; count saturates at 255
    for (int k = 1; k <= 300; k++) begin
      wait_state(2'd3, 40, "sat_reach_run");
      locked = 1'b0;
      tick(1);
      locked = 1'b1;
      tick(2);
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300) begin
        check("sat_state", 32'(state), 0);
        check("sat_count", 32'(lock_loss_count), (k < 255) ? k : 255);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, length of the locked synchronizer chain (legal 2..4).
REQ-002 SHALL have parameter LOCK_CYCLES, default 1024, consecutive synchronized-locked cycles needed to qualify lock (legal 2..65535).
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, cycles between sys_resetb release and ready assertion (legal 1..255).
REQ-004 clock_in  input  1  PLL output clock; the only clock; all state on rising edge.
REQ-005 resetb  input  1  reset, asynchronous and active-low.
REQ-006 locked  input  1  PLL lock indicator, asynchronous to clock_in.
REQ-007 sys_resetb  output  1  active-low reset for downstream logic, registered.
REQ-008 ready  output  1  high when downstream may begin work, registered.
REQ-009 state  output  2  current FSM state encoding (WAIT=0, QUAL=1, HOLD=2, RUN=3).
REQ-010 lock_loss_count  output  8  number of lock losses after qualification, saturating.

Function
REQ-011 locked SHALL pass through a SYNC_STAGES-deep flop chain; locked_s is the last stage; no other logic SHALL sample locked.
REQ-012 FSM states SHALL be WAIT, QUAL, HOLD, RUN; exactly one active per cycle.
REQ-013 WAIT: sys_resetb=0, ready=0, counter cleared; locked_s=1 -> QUAL next cycle.
REQ-014 QUAL: 16-bit counter increments every cycle locked_s=1; locked_s=0 -> WAIT, counter cleared, lock_loss_count unchanged.
REQ-015 QUAL: when counter == LOCK_CYCLES-1 and locked_s=1 -> HOLD; sys_resetb registers 1 on that same edge.
REQ-016 Consequence: sys_resetb rises exactly LOCK_CYCLES clocks after the first cycle in QUAL, provided locked_s stays high.
REQ-017 HOLD: sys_resetb=1, ready=0; counter counts from 0; counter == HOLD_CYCLES-1 with locked_s=1 -> RUN, ready registers 1 on that edge.
REQ-018 RUN: sys_resetb=1, ready=1; remains until locked_s=0.
REQ-019 In HOLD or RUN, locked_s=0 -> WAIT; sys_resetb and ready register 0 on that edge (one-cycle reaction after locked_s falls).
REQ-020 Each HOLD/RUN -> WAIT transition SHALL increment lock_loss_count by 1; at 255 it SHALL hold at 255.
REQ-021 A locked pulse shorter than LOCK_CYCLES (after sync) SHALL never release sys_resetb.
REQ-022 Counter SHALL never wrap; it is cleared on every state entry.
REQ-023 sys_resetb SHALL be glitch-free: driven directly from a flop, no combinational path from locked or resetb except async clear.
REQ-024 state SHALL reflect the registered current state, no lookahead.

Reset
REQ-025 resetb=0 SHALL asynchronously force: state=WAIT, sys_resetb=0, ready=0, counter=0, synchronizer flops=0, lock_loss_count=0.
REQ-026 resetb deassertion SHALL take effect on a clock edge; first possible QUAL entry is SYNC_STAGES+1 edges after resetb rises with locked already high.
REQ-027 resetb asserted mid-HOLD or mid-RUN SHALL drop sys_resetb and ready immediately (asynchronously) and SHALL clear lock_loss_count.

Verification (LOCK_CYCLES=8, HOLD_CYCLES=4, SYNC_STAGES=2)
REQ-028 locked held 1 from reset release -> state WAIT->QUAL at edge 3; sys_resetb=1 at edge 11; ready=1 at edge 15; lock_loss_count=0.
REQ-029 locked high 5 cycles then low, then steady high -> no sys_resetb release during pulse; release 8 cycles after second QUAL entry; count=0.
REQ-030 In RUN, drop locked for 1 cycle -> sys_resetb=0, ready=0 three edges after the drop (2 sync + 1); lock_loss_count=1; full requalification follows.
REQ-031 300 lock losses from RUN -> lock_loss_count saturates at 255.
REQ-032 resetb pulsed low mid-HOLD -> sys_resetb, ready, lock_loss_count, state all 0 without waiting for a clock edge.
REQ-033 locked drops in HOLD at counter=2 -> WAIT, ready never asserts, lock_loss_count increments.
